// File: rtl/breakout_pkg.sv
// Shared playfield geometry, FSM state type and level pattern generator
// for the breakout block field.
package breakout_pkg;

    localparam int unsigned BORDER_WIDTH   = 8;
    localparam int unsigned BLOCK_WIDTH    = 48;
    localparam int unsigned BLOCK_HEIGHT   = 16;
    localparam int unsigned BLOCKS_PER_ROW = 13;
    localparam int unsigned NUM_ROWS       = 16;
    localparam int unsigned NUM_BLOCKS     = BLOCKS_PER_ROW * NUM_ROWS;

    localparam int unsigned HIT_X_W = 10;
    localparam int unsigned HIT_Y_W = 9;
    localparam int unsigned ROW_W   = 4;
    localparam int unsigned COL_W   = 4;
    localparam int unsigned IDX_W   = 8;
    localparam int unsigned LEFT_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DIV,
        ST_CHECK
    } field_state_t;

    // One row of a level layout; bit c is column c.
    function automatic logic [BLOCKS_PER_ROW-1:0] pattern_row(
        input logic [1:0]       level,
        input logic [ROW_W-1:0] row
    );
        logic [BLOCKS_PER_ROW-1:0] bits;
        bits = '0;
        for (int unsigned c = 0; c < BLOCKS_PER_ROW; c++) begin
            case (level)
                2'd0:    bits[c] = 1'b1;
                2'd1:    bits[c] = (row[0] == c[0]);
                2'd2:    bits[c] = ~row[0];
                default: bits[c] = (row < 4'd8);
            endcase
        end
        return bits;
    endfunction

endpackage

// File: rtl/block_field_if.sv
// Hit request/response handshake between the collision logic (master)
// and the block field (slave).
interface block_field_if;
    import breakout_pkg::*;

    logic               hit_req;
    logic [HIT_X_W-1:0] hit_x;
    logic [HIT_Y_W-1:0] hit_y;
    logic               hit_done;
    logic               hit_hit;

    modport master (
        output hit_req,
        output hit_x,
        output hit_y,
        input  hit_done,
        input  hit_hit
    );

    modport slave (
        input  hit_req,
        input  hit_x,
        input  hit_y,
        output hit_done,
        output hit_hit
    );

endinterface

// File: rtl/block_hit_locator.sv
// Maps a pixel hit to {row, col}: combinational range check, then a
// subtractive divide by the block width (column c takes c+1 cycles).
module block_hit_locator #(
    parameter int unsigned BORDER_WIDTH   = 8,
    parameter int unsigned BLOCK_WIDTH    = 48,
    parameter int unsigned BLOCK_HEIGHT   = 16,
    parameter int unsigned BLOCKS_PER_ROW = 13,
    parameter int unsigned NUM_ROWS       = 16
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       i_start,
    input  logic [9:0] i_hit_x,
    input  logic [8:0] i_hit_y,
    output logic       o_valid,
    output logic       o_done,
    output logic [3:0] o_row,
    output logic [3:0] o_col
);

    localparam logic [9:0]  X_LO      = 10'(BORDER_WIDTH);
    localparam logic [9:0]  X_HI      = 10'(BORDER_WIDTH + BLOCKS_PER_ROW * BLOCK_WIDTH);
    localparam logic [8:0]  Y_LO      = 9'(BORDER_WIDTH);
    localparam logic [8:0]  Y_HI      = 9'(BORDER_WIDTH + NUM_ROWS * BLOCK_HEIGHT);
    localparam logic [9:0]  STEP      = 10'(BLOCK_WIDTH);
    localparam int unsigned ROW_SHIFT = $clog2(BLOCK_HEIGHT);

    logic [9:0] r_rem;
    logic [3:0] r_row;
    logic [3:0] r_col;
    logic       r_running;

    logic [9:0] w_rem_start;
    logic [3:0] w_row_start;

    assign o_valid = (i_hit_x >= X_LO) && (i_hit_x < X_HI) &&
                     (i_hit_y >= Y_LO) && (i_hit_y < Y_HI);

    assign w_rem_start = i_hit_x - X_LO;
    assign w_row_start = 4'((i_hit_y - Y_LO) >> ROW_SHIFT);

    // The remainder below one block width means the column count is final.
    assign o_done = r_running && (r_rem < STEP);
    assign o_row  = r_row;
    assign o_col  = r_col;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_rem     <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_running <= 1'b0;
        end else if (i_start) begin
            r_rem     <= w_rem_start;
            r_row     <= w_row_start;
            r_col     <= '0;
            r_running <= 1'b1;
        end else if (r_running) begin
            if (r_rem >= STEP) begin
                r_rem <= r_rem - STEP;
                r_col <= r_col + 4'd1;
            end else begin
                r_running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/block_field.sv
// Playfield occupancy: row-by-row level loads, pixel hit resolution and
// block count. Optional BLOCK_FIELD_SCORE_EN adds a saturating score output.
module block_field
    import breakout_pkg::*;
(
    input  logic                  clk,
    input  logic                  nRst,
    input  logic                  load_level,
    input  logic [1:0]            level,
    block_field_if.slave          hit,
    output logic                  busy,
    output logic [NUM_BLOCKS-1:0] block_state,
    output logic [LEFT_W-1:0]     blocks_left,
    output logic                  level_clear
`ifdef BLOCK_FIELD_SCORE_EN
    ,
    output logic [15:0]           score
`endif
);

    field_state_t r_state;
    field_state_t w_state_nxt;

    logic                      r_load_pending;
    logic [1:0]                r_level;
    logic [ROW_W-1:0]          r_row_cnt;
    logic [NUM_BLOCKS-1:0]     r_block_state;
    logic [LEFT_W-1:0]         r_blocks_left;
    logic                      r_hit_done;
    logic                      r_hit_hit;
    logic                      r_level_clear;

    logic                      w_load_go;
    logic                      w_hit_start;
    logic                      w_hit_reject;
    logic                      w_check;
    logic                      w_present;
    logic                      w_loc_valid;
    logic                      w_loc_done;
    logic [ROW_W-1:0]          w_loc_row;
    logic [COL_W-1:0]          w_loc_col;
    logic [IDX_W-1:0]          w_idx;
    logic [IDX_W-1:0]          w_load_base;
    logic [BLOCKS_PER_ROW-1:0] w_row_bits;
    logic [LEFT_W-1:0]         w_row_pop;

    block_hit_locator #(
        .BORDER_WIDTH   (BORDER_WIDTH),
        .BLOCK_WIDTH    (BLOCK_WIDTH),
        .BLOCK_HEIGHT   (BLOCK_HEIGHT),
        .BLOCKS_PER_ROW (BLOCKS_PER_ROW),
        .NUM_ROWS       (NUM_ROWS)
    ) u_locator (
        .clk     (clk),
        .nRst    (nRst),
        .i_start (w_hit_start),
        .i_hit_x (hit.hit_x),
        .i_hit_y (hit.hit_y),
        .o_valid (w_loc_valid),
        .o_done  (w_loc_done),
        .o_row   (w_loc_row),
        .o_col   (w_loc_col)
    );

    assign w_idx       = {4'b0, w_loc_row} * 8'(BLOCKS_PER_ROW) + {4'b0, w_loc_col};
    assign w_load_base = {4'b0, r_row_cnt} * 8'(BLOCKS_PER_ROW);
    assign w_row_bits  = pattern_row(r_level, r_row_cnt);
    assign w_row_pop   = 8'($countones(w_row_bits));
    assign w_present   = r_block_state[w_idx];

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // hit_req is ignored while hit_done is showing so a held request is
    // not mistaken for a new one before the requester can drop it.
    always_comb begin
        w_state_nxt  = r_state;
        w_load_go    = 1'b0;
        w_hit_start  = 1'b0;
        w_hit_reject = 1'b0;
        w_check      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (load_level || r_load_pending) begin
                    w_load_go   = 1'b1;
                    w_state_nxt = ST_LOAD;
                end else if (hit.hit_req && !r_hit_done) begin
                    if (w_loc_valid) begin
                        w_hit_start = 1'b1;
                        w_state_nxt = ST_DIV;
                    end else begin
                        w_hit_reject = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (r_row_cnt == 4'(NUM_ROWS - 1)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DIV: begin
                if (w_loc_done) begin
                    w_state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                w_check     = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_load_pending <= 1'b0;
            r_level        <= '0;
            r_row_cnt      <= '0;
            r_block_state  <= '0;
            r_blocks_left  <= '0;
            r_hit_done     <= 1'b0;
            r_hit_hit      <= 1'b0;
            r_level_clear  <= 1'b0;
        end else begin
            r_hit_done    <= w_hit_reject | w_check;
            r_hit_hit     <= w_check & w_present;
            r_level_clear <= w_check & w_present & (r_blocks_left == 8'd1);

            if (w_load_go) begin
                r_load_pending <= 1'b0;
            end else if (load_level && (r_state != ST_IDLE)) begin
                r_load_pending <= 1'b1;
            end

            if (w_load_go) begin
                r_level       <= level;
                r_row_cnt     <= '0;
                r_blocks_left <= '0;
            end else if (r_state == ST_LOAD) begin
                r_block_state[w_load_base +: BLOCKS_PER_ROW] <= w_row_bits;
                r_blocks_left <= r_blocks_left + w_row_pop;
                r_row_cnt     <= r_row_cnt + 4'd1;
            end else if (w_check && w_present) begin
                r_block_state[w_idx] <= 1'b0;
                if (r_blocks_left != '0) begin
                    r_blocks_left <= r_blocks_left - 8'd1;
                end
            end
        end
    end

`ifdef BLOCK_FIELD_SCORE_EN
    logic [15:0] r_score;
    logic [16:0] w_score_sum;

    // Top rows are worth more: row r scores 16 - r.
    assign w_score_sum = {1'b0, r_score} + 17'(5'(NUM_ROWS) - {1'b0, w_loc_row});

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_score <= '0;
        end else if (w_check && w_present) begin
            r_score <= w_score_sum[16] ? '1 : w_score_sum[15:0];
        end
    end

    assign score = r_score;
`endif

    assign busy         = (r_state != ST_IDLE);
    assign block_state  = r_block_state;
    assign blocks_left  = r_blocks_left;
    assign level_clear  = r_level_clear;
    assign hit.hit_done = r_hit_done;
    assign hit.hit_hit  = r_hit_hit;

endmodule

// File: tb/tb_block_field.sv
// Randomized self-checking bench for block_field against a playfield model
// built directly from the level rules and pixel geometry.
module tb_block_field;

    logic         clk = 1'b0;
    logic         nRst;
    logic         load_level;
    logic [1:0]   level;
    logic         busy;
    logic [207:0] block_state;
    logic [7:0]   blocks_left;
    logic         level_clear;
`ifdef BLOCK_FIELD_SCORE_EN
    logic [15:0]  score;
`endif

    block_field_if u_if();

    block_field u_dut (
        .clk         (clk),
        .nRst        (nRst),
        .load_level  (load_level),
        .level       (level),
        .hit         (u_if),
        .busy        (busy),
        .block_state (block_state),
        .blocks_left (blocks_left),
        .level_clear (level_clear)
`ifdef BLOCK_FIELD_SCORE_EN
        ,
        .score       (score)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    bit m_field [208];
    int m_left;
    int m_score;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit spec_bit(input int lvl, input int row, input int col);
        case (lvl)
            0:       return 1'b1;
            1:       return ((row + col) % 2) == 0;
            2:       return (row % 2) == 0;
            default: return row < 8;
        endcase
    endfunction

    function automatic logic [207:0] model_vec();
        logic [207:0] v;
        for (int i = 0; i < 208; i++) v[i] = m_field[i];
        return v;
    endfunction

    task automatic model_load(input int lvl);
        m_left = 0;
        for (int i = 0; i < 208; i++) begin
            m_field[i] = spec_bit(lvl, i / 13, i % 13);
            m_left += int'(m_field[i]);
        end
    endtask

    task automatic check_field(input string tag);
        check({tag, "_left"}, blocks_left, m_left);
        check({tag, "_field"}, block_state, model_vec());
`ifdef BLOCK_FIELD_SCORE_EN
        check({tag, "_score"}, score, m_score);
`endif
    endtask

    task automatic do_reset();
        nRst         = 1'b0;
        load_level   = 1'b0;
        level        = 2'd0;
        u_if.hit_req = 1'b0;
        u_if.hit_x   = '0;
        u_if.hit_y   = '0;
        for (int i = 0; i < 208; i++) m_field[i] = 1'b0;
        m_left  = 0;
        m_score = 0;
        repeat (2) @(negedge clk);
        check("rst_hit_done", u_if.hit_done, 0);
        check("rst_hit_hit", u_if.hit_hit, 0);
        check("rst_busy", busy, 0);
        check("rst_level_clear", level_clear, 0);
        check_field("rst");
        nRst = 1'b1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("idle_timeout", n < 200, 1);
    endtask

    task automatic do_load(input int lvl);
        int busy_cycles;
        @(negedge clk);
        while (u_if.hit_done) @(negedge clk);
        load_level = 1'b1;
        level      = 2'(lvl);
        @(negedge clk);
        load_level = 1'b0;
        level      = 2'($urandom);
        busy_cycles = 0;
        while (busy && busy_cycles < 100) begin
            busy_cycles++;
            @(negedge clk);
        end
        model_load(lvl);
        check("load_busy_cycles", busy_cycles, 16);
        check_field("load");
    endtask

    // mode 0: plain hit; 1: load_level raised together with hit_req;
    // 2: load_level pulsed while the hit is still dividing.
    task automatic do_hit(input int x, input int y, input int mode, input int lvl);
        bit inr, seen, exp_hit, exp_lc, hh, lc;
        int col, row, idx, lat, exp_lat, d;
        inr = (x >= 8) && (x < 632) && (y >= 8) && (y < 264);
        col = inr ? (x - 8) / 48 : 0;
        row = inr ? (y - 8) / 16 : 0;
        idx = row * 13 + col;

        @(negedge clk);
        while (u_if.hit_done) @(negedge clk);
        u_if.hit_req = 1'b1;
        u_if.hit_x   = 10'(x);
        u_if.hit_y   = 9'(y);
        if (mode == 1) begin
            load_level = 1'b1;
            level      = 2'(lvl);
        end
        seen = 1'b0;
        lat  = 0;
        for (int k = 1; k <= 100 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (u_if.hit_done) begin
                seen = 1'b1;
                lat  = k;
            end
            if (mode == 1 && k == 1) load_level = 1'b0;
            if (mode == 2 && k == 3) begin
                load_level = 1'b1;
                level      = 2'(lvl);
            end
            if (mode == 2 && k == 4) load_level = 1'b0;
        end
        hh = u_if.hit_hit;
        lc = level_clear;
        u_if.hit_req = 1'b0;

        if (mode == 1) model_load(lvl);
        exp_hit = inr && m_field[idx];
        if (exp_hit) begin
            m_field[idx] = 1'b0;
            m_left--;
            m_score = (m_score + 16 - row > 65535) ? 65535 : m_score + 16 - row;
        end
        exp_lc  = exp_hit && (m_left == 0);
        exp_lat = (inr ? col + 3 : 1) + ((mode == 1) ? 17 : 0);

        check("hit_done_seen", seen, 1);
        check("hit_latency", lat, exp_lat);
        check("hit_hit", hh, exp_hit);
        check("hit_level_clear", lc, exp_lc);
        check_field("hit");

        if (mode == 2) begin
            d = 0;
            for (int k = 1; k <= 10 && d == 0; k++) begin
                @(posedge clk);
                #1;
                if (busy) d = k;
            end
            check("pending_load_start", d, 1);
            wait_idle();
            model_load(lvl);
            check_field("pending_load");
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        int order [104];
        int tmp, j, r, c;

        do_reset();

        do_load(0);
        do_hit(8, 8, 0, 0);
        do_hit(8, 8, 0, 0);
        do_hit(631, 263, 0, 0);
        do_hit(4, 100, 0, 0);
        do_hit(640, 100, 0, 0);
        do_hit(100, 7, 0, 0);
        do_hit(100, 264, 0, 0);
        do_hit(7, 263, 0, 0);
        do_hit(632, 8, 0, 0);
        do_hit(55, 23, 0, 0);
        do_hit(56, 24, 0, 0);
        for (int i = 0; i < 20; i++)
            do_hit(int'($urandom_range(0, 680)), int'($urandom_range(0, 300)), 0, 0);

        do_load(1);
        for (int i = 0; i < 20; i++)
            do_hit(int'($urandom_range(0, 680)), int'($urandom_range(0, 300)), 0, 0);

        do_load(2);
        for (int i = 0; i < 8; i++)
            do_hit(int'($urandom_range(0, 680)), int'($urandom_range(0, 300)), 0, 0);
        do_hit(int'($urandom_range(8, 631)), int'($urandom_range(8, 263)), 1, 0);
        do_hit(int'($urandom_range(8, 631)), int'($urandom_range(8, 263)), 0, 0);

        do_load(3);
        for (int i = 0; i < 104; i++) order[i] = i;
        for (int i = 103; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            tmp = order[i];
            order[i] = order[j];
            order[j] = tmp;
        end
        for (int i = 0; i < 104; i++) begin
            r = order[i] / 13;
            c = order[i] % 13;
            do_hit(8 + c * 48 + int'($urandom_range(0, 47)),
                   8 + r * 16 + int'($urandom_range(0, 15)), 0, 0);
        end
        check("cleared_left", blocks_left, 0);
        do_hit(631, 100, 2, 3);

        @(negedge clk);
        while (u_if.hit_done) @(negedge clk);
        u_if.hit_req = 1'b1;
        u_if.hit_x   = 10'd631;
        u_if.hit_y   = 9'd263;
        repeat (5) @(negedge clk);
        nRst = 1'b0;
        u_if.hit_req = 1'b0;
        #1;
        check("midreset_busy", busy, 0);
        check("midreset_field", block_state, 0);
        check("midreset_left", blocks_left, 0);
        repeat (3) @(negedge clk);
        check("midreset_done", u_if.hit_done, 0);

        do_reset();
        do_load(0);
        do_hit(8, 8, 0, 0);
`ifdef BLOCK_FIELD_SCORE_EN
        check("score_row0", score, 16);
`endif
        do_hit(631, 263, 0, 0);
`ifdef BLOCK_FIELD_SCORE_EN
        check("score_row15", score, 17);
`endif

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
